// File: rtl/pi1_rrarb.sv
`default_nettype none
// ============================================================================
// pi1_rrarb : N-master to 1-slave pi1 arbiter, round-robin or fixed priority.
// Optional watchdog enabled by defining PI1RRARB_TIMEOUT_EN.   Revision 1.0
// ============================================================================
module pi1_rrarb #(
  parameter  int MASTERCOUNT = 2,
  parameter  int ARCHBITSZ   = 32,
  parameter  int ARBMODE     = 0,
  parameter  int TIMEOUT     = 1024,
  localparam int ADDRBITSZ   = ARCHBITSZ - $clog2(ARCHBITSZ/8),
  localparam int SELBITSZ    = ARCHBITSZ/8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [2*MASTERCOUNT-1:0]        m_op_i,
  input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i,
  input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i,
  input  logic [SELBITSZ*MASTERCOUNT-1:0]  m_sel_i,
  output logic [ARCHBITSZ-1:0]            m_data_o,
  output logic [MASTERCOUNT-1:0]          m_rdy_o,
  output logic [1:0]                      s_op_o,
  output logic [ADDRBITSZ-1:0]            s_addr_o,
  output logic [ARCHBITSZ-1:0]            s_data_o,
  output logic [SELBITSZ-1:0]             s_sel_o,
  input  logic [ARCHBITSZ-1:0]            s_data_i,
  input  logic                            s_rdy_i,
  output logic                            err_o
);

  localparam int GW = (MASTERCOUNT > 1) ? $clog2(MASTERCOUNT) : 1;
  localparam int IW = GW + 1;

  localparam logic [1:0] OP_NOOP  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  if (MASTERCOUNT < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("pi1_rrarb: MASTERCOUNT and TIMEOUT must be >= 1");
  end

  logic [1:0]           state_q, state_d;
  logic [GW-1:0]        gnt_q, gnt_d;
  logic [GW-1:0]        ptr_q, ptr_d;
  logic [GW-1:0]        win;
  logic [1:0]           op_q, op_d;
  logic [ADDRBITSZ-1:0] addr_q, addr_d;
  logic [ARCHBITSZ-1:0] wdata_q, wdata_d;
  logic [SELBITSZ-1:0]  sel_q, sel_d;
  logic [ARCHBITSZ-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 any_req;
  logic                 timeout;

  logic [MASTERCOUNT-1:0] req;
  logic [1:0]             op_a   [MASTERCOUNT];
  logic [ADDRBITSZ-1:0]   addr_a [MASTERCOUNT];
  logic [ARCHBITSZ-1:0]   data_a [MASTERCOUNT];
  logic [SELBITSZ-1:0]    sel_a  [MASTERCOUNT];

  for (genvar i = 0; i < MASTERCOUNT; i++) begin : g_split
    assign op_a[i]   = m_op_i[2*i +: 2];
    assign addr_a[i] = m_addr_i[ADDRBITSZ*i +: ADDRBITSZ];
    assign data_a[i] = m_data_i[ARCHBITSZ*i +: ARCHBITSZ];
    assign sel_a[i]  = m_sel_i[SELBITSZ*i +: SELBITSZ];
    assign req[i]    = (op_a[i] != OP_NOOP);
  end

  assign any_req = |req;

  if (ARBMODE == 1) begin : g_fixed
    always_comb begin
      win = '0;
      for (int k = MASTERCOUNT - 1; k >= 0; k--) begin
        if (req[k]) win = GW'(k);
      end
    end
  end else begin : g_rr
    localparam logic [IW-1:0] MC_W = IW'(MASTERCOUNT);
    // Scan ptr, ptr+1, ... with wrap; the first requester found wins.
    always_comb begin
      logic [IW-1:0] idx;
      logic          found;
      win   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < MASTERCOUNT; k++) begin
        idx = {1'b0, ptr_q} + IW'(k);
        if (idx >= MC_W) idx = idx - MC_W;
        if (!found && req[idx[GW-1:0]]) begin
          win   = idx[GW-1:0];
          found = 1'b1;
        end
      end
    end
  end

`ifdef PI1RRARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) cnt_d = '0;
    else if (state_q == ST_ISSUE || state_q == ST_WAIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // A slave response arriving in the last WAIT cycle still counts as completion.
  assign timeout = (state_q == ST_ISSUE || (state_q == ST_WAIT && !s_rdy_i)) &&
                   (cnt_q == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      op_q    <= OP_NOOP;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req) state_d = ST_ISSUE;
      ST_ISSUE: if (s_rdy_i) state_d = ST_WAIT;
      ST_WAIT:  if (s_rdy_i) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    if (timeout) state_d = ST_DONE;
  end

  always_comb begin
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_d   = win;
          op_d    = op_a[win];
          addr_d  = addr_a[win];
          wdata_d = data_a[win];
          sel_d   = sel_a[win];
        end
      end
      ST_ISSUE: if (s_rdy_i) op_d = OP_NOOP;
      ST_WAIT:  if (s_rdy_i) rdata_d = s_data_i;
      default:  ptr_d = (gnt_q == GW'(MASTERCOUNT - 1)) ? '0 : gnt_q + 1'b1;
    endcase
    if (timeout) begin
      op_d    = OP_NOOP;
      rdata_d = '1;
      err_d   = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < MASTERCOUNT; i++) begin
      m_rdy_o[i] = !req[i] || (state_q == ST_DONE && gnt_q == GW'(i));
    end
  end

  assign s_op_o   = op_q;
  assign s_addr_o = addr_q;
  assign s_data_o = wdata_q;
  assign s_sel_o  = sel_q;
  assign m_data_o = rdata_q;
  assign err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pi1_rrarb.sv
`default_nettype none
// ============================================================================
// tb_pi1_rrarb : directed bench for pi1_rrarb, a round-robin and a fixed-priority
// instance driven by the same masters and slave.                 Revision 1.0
// ============================================================================
module tb_pi1_rrarb;
  localparam int MC = 4;
  localparam int AW = 30;

  logic          clk;
  logic          rst_n;
  logic [2*MC-1:0]  m_op;
  logic [AW*MC-1:0] m_addr;
  logic [32*MC-1:0] m_data;
  logic [4*MC-1:0]  m_sel;
  logic [31:0]   s_data;
  logic          s_rdy;

  logic [31:0]   m_data_a, m_data_b, s_data_a, s_data_b;
  logic [MC-1:0] m_rdy_a, m_rdy_b;
  logic [1:0]    s_op_a, s_op_b;
  logic [AW-1:0] s_addr_a, s_addr_b;
  logic [3:0]    s_sel_a, s_sel_b;
  logic          err_a, err_b;

  int checks = 0;
  int failures = 0;

  pi1_rrarb #(.MASTERCOUNT(MC), .ARCHBITSZ(32), .ARBMODE(0), .TIMEOUT(8)) dut_rr (
    .clk_i(clk), .rst_i(rst_n), .m_op_i(m_op), .m_addr_i(m_addr), .m_data_i(m_data),
    .m_sel_i(m_sel), .m_data_o(m_data_a), .m_rdy_o(m_rdy_a), .s_op_o(s_op_a),
    .s_addr_o(s_addr_a), .s_data_o(s_data_a), .s_sel_o(s_sel_a), .s_data_i(s_data),
    .s_rdy_i(s_rdy), .err_o(err_a));

  pi1_rrarb #(.MASTERCOUNT(MC), .ARCHBITSZ(32), .ARBMODE(1), .TIMEOUT(8)) dut_fp (
    .clk_i(clk), .rst_i(rst_n), .m_op_i(m_op), .m_addr_i(m_addr), .m_data_i(m_data),
    .m_sel_i(m_sel), .m_data_o(m_data_b), .m_rdy_o(m_rdy_b), .s_op_o(s_op_b),
    .s_addr_o(s_addr_b), .s_data_o(s_data_b), .s_sel_o(s_sel_b), .s_data_i(s_data),
    .s_rdy_i(s_rdy), .err_o(err_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [1:0] op);
    m_op[2*i +: 2] = op;
  endtask

  task automatic set_master(input int i, input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] s);
    m_addr[AW*i +: AW] = a;
    m_data[32*i +: 32] = d;
    m_sel[4*i +: 4]    = s;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    m_op  = '0;
    s_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; m_op = '0; m_addr = '0; m_data = '0; m_sel = '0; s_data = '0; s_rdy = 1'b1;
    tick;
    checks++; if (m_rdy_a !== 4'hF) begin failures++; $display("FAIL reset_rdy: got %h want f", m_rdy_a); end
    checks++; if (s_op_a !== 2'd0) begin failures++; $display("FAIL reset_sop: got %0d want 0", s_op_a); end
    checks++; if (m_data_a !== 32'h0) begin failures++; $display("FAIL reset_mdata: got %h want 0", m_data_a); end
    checks++; if (err_a !== 1'b0 || err_b !== 1'b0) begin failures++; $display("FAIL reset_err: got %b%b want 00", err_a, err_b); end
    checks++; if (s_addr_a !== '0 || s_sel_a !== 4'h0) begin failures++; $display("FAIL reset_saddr: got %h/%h want 0/0", s_addr_a, s_sel_a); end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single_read;
    s_rdy = 1'b1; s_data = 32'hDEADBEEF;
    set_master(0, 30'h10, 32'h0, 4'hF);
    set_op(0, 2'd2);
    #1;
    checks++; if (m_rdy_a[0] !== 1'b0) begin failures++; $display("FAIL rd_req_rdy: got %b want 0", m_rdy_a[0]); end
    tick;
    checks++; if (s_op_a !== 2'd2 || s_addr_a !== 30'h10) begin failures++; $display("FAIL rd_issue: got op %0d addr %h want op 2 addr 10", s_op_a, s_addr_a); end
    tick;
    checks++; if (s_op_a !== 2'd0 || m_rdy_a[0] !== 1'b0) begin failures++; $display("FAIL rd_wait: got op %0d rdy %b want op 0 rdy 0", s_op_a, m_rdy_a[0]); end
    tick;
    checks++; if (m_rdy_a !== 4'hF) begin failures++; $display("FAIL rd_done_rdy: got %h want f", m_rdy_a); end
    checks++; if (m_data_a !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_done_data: got %h want deadbeef", m_data_a); end
    set_op(0, 2'd0);
    tick;
    checks++; if (s_op_a !== 2'd0) begin failures++; $display("FAIL rd_idle_sop: got %0d want 0", s_op_a); end
  endtask

  task automatic test_round_robin;
    int exp;
    do_reset;
    s_data = 32'h5555AAAA;
    for (int i = 0; i < MC; i++) begin
      set_master(i, 30'h100 + 30'(i), 32'hA0 + 32'(i), 4'(i + 1));
      set_op(i, 2'd1);
    end
    for (int t = 0; t < 5; t++) begin
      exp = t % MC;
      tick;
      checks++; if (s_op_a !== 2'd1 || s_addr_a !== 30'h100 + 30'(exp)) begin failures++; $display("FAIL rr_issue_%0d: got op %0d addr %h want op 1 addr %h", t, s_op_a, s_addr_a, 30'h100 + 30'(exp)); end
      checks++; if (s_data_a !== 32'hA0 + 32'(exp) || s_sel_a !== 4'(exp + 1)) begin failures++; $display("FAIL rr_wdata_%0d: got %h/%h want %h/%h", t, s_data_a, s_sel_a, 32'hA0 + 32'(exp), 4'(exp + 1)); end
      tick;
      tick;
      checks++; if (m_rdy_a !== 4'(1 << exp)) begin failures++; $display("FAIL rr_done_%0d: got %b want %b", t, m_rdy_a, 4'(1 << exp)); end
      checks++; if (m_rdy_b !== 4'b0001) begin failures++; $display("FAIL fp_all_%0d: got %b want 0001", t, m_rdy_b); end
      checks++; if (m_data_a !== 32'h5555AAAA) begin failures++; $display("FAIL rr_wr_data_%0d: got %h want 5555aaaa", t, m_data_a); end
      tick;
    end
    m_op = '0;
  endtask

  task automatic test_fixed_priority;
    logic [AW-1:0] exp_a;
    do_reset;
    set_master(1, 30'h201, 32'h0, 4'hF);
    set_master(3, 30'h203, 32'h0, 4'hF);
    set_op(1, 2'd2);
    set_op(3, 2'd2);
    for (int t = 0; t < 3; t++) begin
      exp_a = (t % 2 == 1) ? 30'h203 : 30'h201;
      tick;
      checks++; if (s_addr_b !== 30'h201) begin failures++; $display("FAIL fp_grant_%0d: got %h want 201", t, s_addr_b); end
      checks++; if (s_addr_a !== exp_a) begin failures++; $display("FAIL rr_pair_%0d: got %h want %h", t, s_addr_a, exp_a); end
      tick;
      tick;
      checks++; if (m_rdy_b !== 4'b0111) begin failures++; $display("FAIL fp_done_%0d: got %b want 0111", t, m_rdy_b); end
      checks++; if (m_rdy_a !== ((t % 2 == 1) ? 4'b1101 : 4'b0111)) begin failures++; $display("FAIL rr_pair_done_%0d: got %b", t, m_rdy_a); end
      if (t == 2) set_op(1, 2'd0);
      tick;
    end
    tick;
    checks++; if (s_addr_b !== 30'h203 || s_addr_a !== 30'h203) begin failures++; $display("FAIL fp_starve_end: got %h/%h want 203/203", s_addr_b, s_addr_a); end
    tick;
    tick;
    checks++; if (m_rdy_b !== 4'hF || m_rdy_a !== 4'hF) begin failures++; $display("FAIL fp_m3_done: got %b/%b want 1111/1111", m_rdy_b, m_rdy_a); end
    set_op(3, 2'd0);
    tick;
  endtask

  task automatic test_wait_stall;
    do_reset;
    s_rdy = 1'b1; s_data = 32'h0;
    set_master(2, 30'h22, 32'h0, 4'hF);
    set_op(2, 2'd2);
    tick;
    checks++; if (s_op_a !== 2'd2) begin failures++; $display("FAIL stall_issue: got %0d want 2", s_op_a); end
    tick;
    s_rdy = 1'b0;
    for (int k = 2; k <= 7; k++) begin
      checks++; if (m_rdy_a[2] !== 1'b0 || s_op_a !== 2'd0 || m_data_a !== 32'h0) begin failures++; $display("FAIL stall_c%0d: got rdy %b op %0d data %h want 0 0 0", k, m_rdy_a[2], s_op_a, m_data_a); end
      if (k < 7) tick;
    end
    s_rdy = 1'b1; s_data = 32'hCAFEF00D;
    tick;
    checks++; if (m_rdy_a[2] !== 1'b1 || m_data_a !== 32'hCAFEF00D) begin failures++; $display("FAIL stall_done: got rdy %b data %h want 1 cafef00d", m_rdy_a[2], m_data_a); end
    set_op(2, 2'd0);
    tick;
    // Second transaction: master withdraws its op while the slave is stalling.
    s_data = 32'h0;
    set_master(2, 30'h33, 32'h0, 4'hF);
    set_op(2, 2'd2);
    tick;
    checks++; if (s_op_a !== 2'd2 || s_addr_a !== 30'h33) begin failures++; $display("FAIL drop_issue: got op %0d addr %h want 2 33", s_op_a, s_addr_a); end
    tick;
    s_rdy = 1'b0;
    tick;
    set_op(2, 2'd0);
    #1;
    checks++; if (m_rdy_a !== 4'hF) begin failures++; $display("FAIL drop_rdy: got %b want 1111", m_rdy_a); end
    tick;
    s_rdy = 1'b1; s_data = 32'h12345678;
    tick;
    checks++; if (m_data_a !== 32'h12345678) begin failures++; $display("FAIL drop_done_data: got %h want 12345678", m_data_a); end
    tick;
    tick;
    checks++; if (s_op_a !== 2'd0) begin failures++; $display("FAIL drop_no_reissue: got %0d want 0", s_op_a); end
  endtask

  task automatic test_reset_midwait;
    s_rdy = 1'b1;
    set_master(0, 30'h44, 32'h0, 4'hF);
    set_op(0, 2'd2);
    tick;
    tick;
    s_rdy = 1'b0;
    tick;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (s_op_a !== 2'd0 || m_data_a !== 32'h0) begin failures++; $display("FAIL rst_async: got op %0d data %h want 0 0", s_op_a, m_data_a); end
    checks++; if (m_rdy_a !== 4'hE) begin failures++; $display("FAIL rst_async_rdy: got %b want 1110", m_rdy_a); end
    @(negedge clk);
    rst_n = 1'b1; s_rdy = 1'b1; s_data = 32'h0BADF00D;
    tick;
    checks++; if (s_op_a !== 2'd2 || s_addr_a !== 30'h44) begin failures++; $display("FAIL rst_restart: got op %0d addr %h want 2 44", s_op_a, s_addr_a); end
    tick;
    tick;
    checks++; if (m_rdy_a[0] !== 1'b1 || m_data_a !== 32'h0BADF00D) begin failures++; $display("FAIL rst_restart_done: got %b %h want 1 0badf00d", m_rdy_a[0], m_data_a); end
    set_op(0, 2'd0);
    tick;
  endtask

  task automatic test_timeout;
    do_reset;
    s_rdy = 1'b0;
    set_master(0, 30'h55, 32'h0, 4'hF);
    set_op(0, 2'd2);
`ifdef PI1RRARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      tick;
      checks++; if (err_a !== 1'b0 || m_rdy_a[0] !== 1'b0) begin failures++; $display("FAIL to_early_c%0d: got err %b rdy %b want 0 0", k, err_a, m_rdy_a[0]); end
    end
    tick;
    checks++; if (err_a !== 1'b1 || m_data_a !== 32'hFFFFFFFF) begin failures++; $display("FAIL to_fire: got err %b data %h want 1 ffffffff", err_a, m_data_a); end
    checks++; if (m_rdy_a[0] !== 1'b1 || s_op_a !== 2'd0) begin failures++; $display("FAIL to_done: got rdy %b op %0d want 1 0", m_rdy_a[0], s_op_a); end
    set_op(0, 2'd0);
    tick;
    checks++; if (err_a !== 1'b0 || m_rdy_a !== 4'hF) begin failures++; $display("FAIL to_idle: got err %b rdy %b want 0 1111", err_a, m_rdy_a); end
`else
    for (int k = 1; k <= 12; k++) begin
      tick;
      checks++; if (err_a !== 1'b0 || m_rdy_a[0] !== 1'b0 || s_op_a !== 2'd2) begin failures++; $display("FAIL hold_c%0d: got err %b rdy %b op %0d want 0 0 2", k, err_a, m_rdy_a[0], s_op_a); end
    end
    do_reset;
`endif
    s_rdy = 1'b1;
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_round_robin;
    test_fixed_priority;
    test_wait_stall;
    test_reset_midwait;
    test_timeout;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
